// File: rtl/pulp_clock_switch_ctrl.sv
// Sequencing controller for a glitch-safe switch between two clock sources.
// It closes the downstream clock gate, flips the mux select, then reopens the gate, with settle delays between steps.
module pulp_clock_switch_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic        INIT_SEL      = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  input  logic req_sel_i,
  input  logic test_en_i,
  output logic ack_o,
  output logic busy_o,
  output logic sel_o,
  output logic clk_en_o
);

  localparam int unsigned   CW       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATE_OFF = 2'd1,
    SWITCH   = 2'd2,
    ACK      = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          sel_r, sel_s;
  logic          tgt_r, tgt_s;
  logic          en_r, en_s;
  logic          ack_r, ack_s;
  logic          busy_r, busy_s;

  // Next-state and next-output logic
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    sel_s   = sel_r;
    tgt_s   = tgt_r;
    en_s    = en_r;
    ack_s   = ack_r;
    busy_s  = busy_r;
    case (state_r)
      IDLE: begin
        if (req_i) begin
          if (req_sel_i != sel_r) begin
            tgt_s   = req_sel_i;
            en_s    = 1'b0;
            busy_s  = 1'b1;
            cnt_s   = CNT_LOAD;
            state_s = GATE_OFF;
          end else begin
            state_s = ACK;
          end
        end else begin
          state_s = IDLE;
        end
      end
      GATE_OFF: begin
        if (cnt_r == CNT_ZERO) begin
          sel_s   = tgt_r;
          cnt_s   = CNT_LOAD;
          state_s = SWITCH;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      SWITCH: begin
        if (cnt_r == CNT_ZERO) begin
          en_s    = 1'b1;
          ack_s   = 1'b1;
          busy_s  = 1'b0;
          state_s = ACK;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ACK: begin
        // A no-op accept arrives here with ack low; raise it before honouring a dropped req.
        if (!ack_r) begin
          ack_s = 1'b1;
        end else if (!req_i) begin
          ack_s   = 1'b0;
          state_s = IDLE;
        end else begin
          ack_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      sel_r   <= INIT_SEL;
      tgt_r   <= INIT_SEL;
      en_r    <= 1'b1;
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      sel_r   <= sel_s;
      tgt_r   <= tgt_s;
      en_r    <= en_s;
      ack_r   <= ack_s;
      busy_r  <= busy_s;
    end
  end

  assign ack_o    = ack_r;
  assign busy_o   = busy_r;
  assign sel_o    = sel_r;
  // Scan mode must always see a running clock, so it bypasses the register here.
  assign clk_en_o = en_r | test_en_i;

endmodule

// File: tb/tb_pulp_clock_switch_ctrl.sv
// Self-checking bench for pulp_clock_switch_ctrl: vector table, corner sequences and randomized
// stimulus against a timestamp-based reference model.
module tb_pulp_clock_switch_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic req, rsel, te;
  logic ack, busy, sel, en;
  logic req1, rsel1;
  logic ack1, busy1, sel1, en1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulp_clock_switch_ctrl #(.SETTLE_CYCLES(4), .INIT_SEL(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_sel_i(rsel), .test_en_i(te),
    .ack_o(ack), .busy_o(busy), .sel_o(sel), .clk_en_o(en)
  );

  pulp_clock_switch_ctrl #(.SETTLE_CYCLES(1), .INIT_SEL(1'b0)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req1), .req_sel_i(rsel1), .test_en_i(te),
    .ack_o(ack1), .busy_o(busy1), .sel_o(sel1), .clk_en_o(en1)
  );

  typedef struct {
    logic req, rsel, te;
    logic esel, een, eack, ebusy;
  } vec_t;

  // mode: 0 idle, 1 switching since cycle t0, 2 no-op accepted, 3 acked and waiting for req low
  typedef struct {
    int   mode;
    int   t0;
    int   k;
    logic tgt, sel, en, ack, busy;
  } mdl_t;

  vec_t vecs[24];
  mdl_t m4, m1;

  task automatic chk(input string nm, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0b expected=%0b", nm, a, e);
    end
  endtask

  task automatic chk4(input string nm, input logic s_e, input logic en_e, input logic ack_e, input logic busy_e);
    chk({nm, "_sel"}, sel, s_e);
    chk({nm, "_en"}, en, en_e);
    chk({nm, "_ack"}, ack, ack_e);
    chk({nm, "_busy"}, busy, busy_e);
  endtask

  function automatic vec_t v(input logic r, input logic rs, input logic t,
                             input logic es, input logic ee, input logic ea, input logic eb);
    vec_t x;
    x.req = r; x.rsel = rs; x.te = t; x.esel = es; x.een = ee; x.eack = ea; x.ebusy = eb;
    return x;
  endfunction

  function automatic mdl_t mreset();
    mdl_t m;
    m.mode = 0; m.t0 = 0; m.k = 0;
    m.tgt = 1'b0; m.sel = 1'b0; m.en = 1'b1; m.ack = 1'b0; m.busy = 1'b0;
    return m;
  endfunction

  // Outputs follow from cycles elapsed since accept: select at +s, gate and ack at +2s.
  function automatic mdl_t mstep(input mdl_t mi, input int s, input logic r, input logic rs);
    mdl_t m;
    m = mi;
    m.k++;
    case (m.mode)
      0: if (r) begin
           if (rs != m.sel) begin
             m.mode = 1; m.t0 = m.k; m.tgt = rs; m.en = 1'b0; m.busy = 1'b1;
           end else begin
             m.mode = 2;
           end
         end
      1: begin
           if (m.k - m.t0 == s) m.sel = m.tgt;
           if (m.k - m.t0 == 2 * s) begin
             m.en = 1'b1; m.ack = 1'b1; m.busy = 1'b0; m.mode = 3;
           end
         end
      2: begin m.ack = 1'b1; m.mode = 3; end
      3: if (!r) begin m.ack = 1'b0; m.mode = 0; end
      default: m.mode = 0;
    endcase
    return m;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; rsel = 1'b0; te = 1'b0; req1 = 1'b0; rsel1 = 1'b0;

    //                req rsel te   sel en ack busy
    vecs[0]  = v(1, 1, 0,  0, 0, 0, 1);
    vecs[1]  = v(1, 0, 0,  0, 0, 0, 1);
    vecs[2]  = v(0, 1, 0,  0, 0, 0, 1);
    vecs[3]  = v(1, 0, 0,  0, 0, 0, 1);
    vecs[4]  = v(1, 1, 0,  1, 0, 0, 1);
    vecs[5]  = v(1, 0, 0,  1, 0, 0, 1);
    vecs[6]  = v(1, 0, 0,  1, 0, 0, 1);
    vecs[7]  = v(1, 0, 0,  1, 0, 0, 1);
    vecs[8]  = v(1, 0, 0,  1, 1, 1, 0);
    vecs[9]  = v(1, 0, 0,  1, 1, 1, 0);
    vecs[10] = v(0, 0, 0,  1, 1, 0, 0);
    vecs[11] = v(1, 1, 0,  1, 1, 0, 0);
    vecs[12] = v(1, 1, 0,  1, 1, 1, 0);
    vecs[13] = v(0, 1, 0,  1, 1, 0, 0);
    vecs[14] = v(1, 0, 1,  1, 1, 0, 1);
    vecs[15] = v(1, 1, 1,  1, 1, 0, 1);
    vecs[16] = v(1, 1, 0,  1, 0, 0, 1);
    vecs[17] = v(1, 1, 1,  1, 1, 0, 1);
    vecs[18] = v(1, 1, 1,  0, 1, 0, 1);
    vecs[19] = v(1, 1, 1,  0, 1, 0, 1);
    vecs[20] = v(1, 1, 1,  0, 1, 0, 1);
    vecs[21] = v(1, 1, 1,  0, 1, 0, 1);
    vecs[22] = v(1, 1, 0,  0, 1, 1, 0);
    vecs[23] = v(0, 1, 0,  0, 1, 0, 0);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk4("reset", 1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Vector table: switch 0->1, no-op accept, switch 1->0 under test mode
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      req = vecs[i].req; rsel = vecs[i].rsel; te = vecs[i].te;
      @(posedge clk);
      #1;
      chk4($sformatf("row%0d", i), vecs[i].esel, vecs[i].een, vecs[i].eack, vecs[i].ebusy);
    end

    // Reset asserted after edge 5 of a 0->1 switch
    @(negedge clk);
    req = 1'b1; rsel = 1'b1; te = 1'b0;
    for (int e = 0; e <= 5; e++) @(posedge clk);
    #1;
    chk("midrst_pre_sel", sel, 1'b1);
    rst_n = 1'b0;
    #1;
    chk4("midrst", 1'b0, 1'b1, 1'b0, 1'b0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      chk4($sformatf("postrst%0d", c), 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // Single-cycle settle instance
    @(negedge clk);
    req1 = 1'b1; rsel1 = 1'b1;
    @(posedge clk); #1;
    chk("s1_e0_en", en1, 1'b0); chk("s1_e0_busy", busy1, 1'b1); chk("s1_e0_sel", sel1, 1'b0);
    @(posedge clk); #1;
    chk("s1_e1_sel", sel1, 1'b1); chk("s1_e1_ack", ack1, 1'b0); chk("s1_e1_en", en1, 1'b0);
    @(posedge clk); #1;
    chk("s1_e2_ack", ack1, 1'b1); chk("s1_e2_en", en1, 1'b1); chk("s1_e2_busy", busy1, 1'b0);
    @(negedge clk);
    req1 = 1'b0;
    @(posedge clk); #1;
    chk("s1_drop_ack", ack1, 1'b0);

    // Randomized stimulus against the reference model, both instances
    do_reset();
    m4 = mreset();
    m1 = mreset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      req  = ($urandom_range(0, 3) != 0);
      rsel = $urandom_range(0, 1) != 0;
      te   = ($urandom_range(0, 7) == 0);
      req1 = req; rsel1 = rsel;
      @(posedge clk);
      m4 = mstep(m4, 4, req, rsel);
      m1 = mstep(m1, 1, req, rsel);
      #1;
      chk($sformatf("rnd%0d_sel", c), sel, m4.sel);
      chk($sformatf("rnd%0d_en", c), en, m4.en | te);
      chk($sformatf("rnd%0d_ack", c), ack, m4.ack);
      chk($sformatf("rnd%0d_busy", c), busy, m4.busy);
      chk($sformatf("rnd%0d_s1_sel", c), sel1, m1.sel);
      chk($sformatf("rnd%0d_s1_en", c), en1, m1.en | te);
      chk($sformatf("rnd%0d_s1_ack", c), ack1, m1.ack);
      chk($sformatf("rnd%0d_s1_busy", c), busy1, m1.busy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
